// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: address/instruction widths, fetch FSM encoding
// and the fetch-entry layout handed to decode.
// No logic; pure type/constant definitions.
package if_fetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  // Fetch responder state: how many requests are in flight and whether the
  // in-flight one still belongs to the current instruction stream.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // nothing outstanding
    WAIT_RSP = 2'd1,  // one request outstanding, response will be queued
    DROP     = 2'd2   // one request outstanding, response will be discarded
  } fetch_state_t;

  // One fetched instruction with the PC it came from; decode reuses this.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus_2;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: 2-entry in-order FIFO holding fetched instructions for IF/ID.
// Latency: push visible at head the cycle after; head is combinational.
// Backpressure: caller must never push when full; clear beats push/pop.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   push, push_entry  enqueue one fetch entry
//   pop               dequeue the head
//   clear             drop every entry (redirect)
//   count             number of valid entries (0..2)
//   head              oldest entry, meaningful only when count != 0
module fetch_queue
  import if_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t store [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (clear) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset; entries are only observed through count.
  always_ff @(posedge clk) begin
    if (rst && !clear && push) store[wr_ptr] <= push_entry;
  end

  assign head = store[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose: issues single-word imem fetches at pc, queues returns toward IF/ID.
// Latency: request combinational from pc; instruction visible the cycle after rsp.
// Backpressure: stops fetching when the 2-entry queue could overflow; PC holds.
//
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   pc, pc_plus_2                   current PC and PC+2 from the PC register
//   flush                           redirect; PC loads its new target via pc_write
//   pc_write                        PC register write enable
//   imem_req_valid/ready, imem_addr fetch request channel (addr = pc)
//   imem_rsp_valid, imem_rsp_data   fetch response, at most one outstanding
//   if_valid, if_instr, if_pc,
//   if_pc_plus_2                    queue head toward IF/ID
//   id_ready                        decode accepts the head
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  // Widths must match the package, which fixes the fetch-entry layout.
  parameter int ADDR_W    = if_fetch_unit_pkg::ADDR_W,
  parameter int INSTR_W   = if_fetch_unit_pkg::INSTR_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  pc_plus_2,
  input  logic               flush,
  output logic               pc_write,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus_2,
  input  logic               id_ready
);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [ADDR_W-1:0]  req_pc;
  logic [ADDR_W-1:0]  req_pc2;

  logic [1:0]         count;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;
  logic               push;
  logic               pop;
  logic               accept;
  logic               wait_rsp;
  logic [2:0]         occ;

  assign wait_rsp = (state == WAIT_RSP);
  assign if_valid = rst & (count != 2'd0);
  assign pop      = if_valid & id_ready & ~flush;

  // Slots committed after this cycle: queued entries plus the live in-flight
  // fetch, minus what decode takes now. A new fetch needs one slot spare.
  assign occ = {1'b0, count} + {2'b0, wait_rsp} - {2'b0, pop};

  // Issuing in WAIT_RSP is allowed only as the previous response lands,
  // which keeps at most one request outstanding yet streams 1/cycle.
  assign imem_req_valid = rst & ~flush
                        & ((state == IDLE) | (wait_rsp & imem_rsp_valid))
                        & (occ <= 3'(BUF_DEPTH - 1));
  assign imem_addr      = pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign pc_write       = rst & (accept | flush);

  assign push       = wait_rsp & imem_rsp_valid & ~flush;
  assign push_entry = '{instr: imem_rsp_data, pc: req_pc, pc_plus_2: req_pc2};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (flush)               state_nxt = imem_rsp_valid ? IDLE : DROP;
        else if (imem_rsp_valid) state_nxt = accept ? WAIT_RSP : IDLE;
      end
      DROP: begin
        // The stale response retires the outstanding slot even under flush.
        if (imem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      req_pc  <= '0;
      req_pc2 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_pc  <= pc;
        req_pc2 <= pc_plus_2;
      end
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (flush),
    .count      (count),
    .head       (head)
  );

  assign if_instr     = head.instr;
  assign if_pc        = head.pc;
  assign if_pc_plus_2 = head.pc_plus_2;

endmodule
